// File: rtl/br_pkg.sv
// Shared decode constants and types for the EX-stage branch resolver.
package br_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef enum logic [1:0] {
    IDLE,
    REDIR,
    FLUSH
  } state_t;

  typedef enum logic [2:0] {
    CT_NONE,
    CT_BEQ,
    CT_BNE,
    CT_JAL,
    CT_JALR
  } ctrl_t;

  // Immediates are produced at 32 bits and sign-extended to XLEN by the consumer.
  typedef logic signed [31:0] imm_t;

endpackage

// File: rtl/branch_imm_gen.sv
// Combinational immediate extraction (B/J/I) and control-flow decode.
module branch_imm_gen
  import br_pkg::*;
(
  input  logic [31:0] instr,
  output imm_t        imm_b,
  output imm_t        imm_j,
  output imm_t        imm_i,
  output ctrl_t       kind,
  output logic        is_ctrl
);

  assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_i = {{20{instr[31]}}, instr[31:20]};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    kind = CT_NONE;
    case (instr[6:0])
      OPC_BRANCH: begin
        if (instr[14:12] == F3_BEQ)      kind = CT_BEQ;
        else if (instr[14:12] == F3_BNE) kind = CT_BNE;
      end
      OPC_JAL:  kind = CT_JAL;
      OPC_JALR: kind = CT_JALR;
      default:  kind = CT_NONE;
    endcase
  end

  assign is_ctrl = (kind != CT_NONE);

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolver: checks the fetch prediction, issues a held redirect
// plus multi-cycle flush on mispredict, and keeps saturating statistics.
module branch_resolve_unit
  import br_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic [31:0]      ex_instr,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pred_pc,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  output logic [XLEN-1:0]  link_data,
  output logic             redir_valid,
  input  logic             redir_ready,
  output logic [XLEN-1:0]  redir_pc,
  output logic             flush,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] misp_cnt
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

  imm_t            imm_b, imm_j, imm_i;
  ctrl_t           kind;
  logic            is_ctrl;
  logic            taken, misp, resolve;
  logic [XLEN-1:0] target, pc_plus4, correct_pc;

  state_t          state_q;
  logic [FC_W-1:0] fcnt_q;
  logic            redir_valid_q, flush_q, ex_ready_q;
  logic [XLEN-1:0] redir_pc_q;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d, misp_cnt_q, misp_cnt_d;

  branch_imm_gen u_imm (
    .instr   (ex_instr),
    .imm_b   (imm_b),
    .imm_j   (imm_j),
    .imm_i   (imm_i),
    .kind    (kind),
    .is_ctrl (is_ctrl)
  );

  assign pc_plus4  = ex_pc + XLEN'(4);
  assign link_data = pc_plus4;

  always_comb begin
    taken  = 1'b0;
    target = ex_pc + XLEN'(imm_b);
    case (kind)
      CT_BEQ:  taken = (rs1_data == rs2_data);
      CT_BNE:  taken = (rs1_data != rs2_data);
      CT_JAL: begin
        taken  = 1'b1;
        target = ex_pc + XLEN'(imm_j);
      end
      CT_JALR: begin
        taken  = 1'b1;
        target = (rs1_data + XLEN'(imm_i)) & ~XLEN'(1);
      end
      default: taken = 1'b0;
    endcase
  end

  assign correct_pc = taken ? target : pc_plus4;
  assign misp       = (taken != ex_pred_taken) || (taken && (target != ex_pred_pc));
  // Instructions offered while not ready are already flushed and never resolve.
  assign resolve    = ex_valid && ex_ready_q && is_ctrl;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      fcnt_q        <= '0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      flush_q       <= 1'b0;
      ex_ready_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (resolve && misp) begin
            state_q       <= REDIR;
            redir_pc_q    <= correct_pc;
            redir_valid_q <= 1'b1;
            flush_q       <= 1'b1;
            ex_ready_q    <= 1'b0;
          end
        end
        REDIR: begin
          if (redir_ready) begin
            redir_valid_q <= 1'b0;
            if (FLUSH_CYCLES == 0) begin
              state_q    <= IDLE;
              flush_q    <= 1'b0;
              ex_ready_q <= 1'b1;
            end else begin
              state_q <= FLUSH;
              fcnt_q  <= FC_W'(FLUSH_CYCLES);
            end
          end
        end
        FLUSH: begin
          if (fcnt_q == FC_W'(1)) begin
            state_q    <= IDLE;
            flush_q    <= 1'b0;
            ex_ready_q <= 1'b1;
          end else begin
            fcnt_q <= fcnt_q - FC_W'(1);
          end
        end
        default: begin
          state_q       <= IDLE;
          redir_valid_q <= 1'b0;
          flush_q       <= 1'b0;
          ex_ready_q    <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    br_cnt_d   = br_cnt_q;
    misp_cnt_d = misp_cnt_q;
    if (resolve) begin
      if (br_cnt_q != '1) br_cnt_d = br_cnt_q + CNT_W'(1);
      if (misp && (misp_cnt_q != '1)) misp_cnt_d = misp_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_cnt_q   <= '0;
      misp_cnt_q <= '0;
    end else begin
      br_cnt_q   <= br_cnt_d;
      misp_cnt_q <= misp_cnt_d;
    end
  end

  assign ex_ready    = ex_ready_q;
  assign redir_valid = redir_valid_q;
  assign redir_pc    = redir_pc_q;
  assign flush       = flush_q;
  assign br_cnt      = br_cnt_q;
  assign misp_cnt    = misp_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit with narrow counters to reach saturation.
module tb_branch_resolve_unit;

  localparam int XLEN = 32;
  localparam int FC   = 2;
  localparam int CW   = 2;

  logic            clk, rst_n;
  logic            ex_valid, ex_ready, ex_pred_taken;
  logic [31:0]     ex_instr;
  logic [XLEN-1:0] ex_pc, ex_pred_pc, rs1_data, rs2_data, link_data, redir_pc;
  logic            redir_valid, redir_ready, flush;
  logic [CW-1:0]   br_cnt, misp_cnt;

  branch_resolve_unit #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_instr      (ex_instr),
    .ex_pc         (ex_pc),
    .ex_pred_taken (ex_pred_taken),
    .ex_pred_pc    (ex_pred_pc),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .link_data     (link_data),
    .redir_valid   (redir_valid),
    .redir_ready   (redir_ready),
    .redir_pc      (redir_pc),
    .flush         (flush),
    .br_cnt        (br_cnt),
    .misp_cnt      (misp_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum {K_BEQ, K_BNE, K_BLT, K_JAL, K_JALR, K_ADDI} kind_t;

  typedef struct {
    logic        misp;
    logic [31:0] pc;
    logic [31:0] br;
    logic [31:0] mp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_br     = 0;
  int   m_mp     = 0;
  localparam int SAT = (1 << CW) - 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input kind_t k, input logic [31:0] imm);
    case (k)
      K_BEQ:  return {imm[12], imm[10:5], 5'd2, 5'd1, 3'b000, imm[4:1], imm[11], 7'b1100011};
      K_BNE:  return {imm[12], imm[10:5], 5'd2, 5'd1, 3'b001, imm[4:1], imm[11], 7'b1100011};
      K_BLT:  return {imm[12], imm[10:5], 5'd2, 5'd1, 3'b100, imm[4:1], imm[11], 7'b1100011};
      K_JAL:  return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
      K_JALR: return {imm[11:0], 5'd1, 3'b000, 5'd1, 7'b1100111};
      default: return {imm[11:0], 5'd1, 3'b000, 5'd1, 7'b0010011};
    endcase
  endfunction

  // Reference outcome computed from the intended immediate, not from instruction bits.
  task automatic model(input kind_t k, input logic [31:0] pc, imm, r1, r2,
                       input logic pt, input logic [31:0] ppc,
                       output logic ctrl, output logic misp, output logic [31:0] cpc);
    logic        tk;
    logic [31:0] tgt;
    ctrl = 1'b1;
    tk   = 1'b0;
    tgt  = pc + imm;
    case (k)
      K_BEQ:  tk = (r1 == r2);
      K_BNE:  tk = (r1 != r2);
      K_JAL:  tk = 1'b1;
      K_JALR: begin tk = 1'b1; tgt = (r1 + imm) & 32'hFFFF_FFFE; end
      default: ctrl = 1'b0;
    endcase
    cpc  = tk ? tgt : pc + 32'd4;
    misp = ctrl && ((tk != pt) || (tk && (tgt != ppc)));
  endtask

  task automatic issue(input string tag, input kind_t k, input logic [31:0] pc, imm, r1, r2,
                       input logic pt, input logic [31:0] ppc, input int w);
    logic        ctrl, misp;
    logic [31:0] cpc;
    exp_t        e;
    int          fl;
    model(k, pc, imm, r1, r2, pt, ppc, ctrl, misp, cpc);
    if (ctrl) begin
      if (m_br < SAT) m_br++;
      if (misp && m_mp < SAT) m_mp++;
    end
    e.misp = misp;
    e.pc   = cpc;
    e.br   = m_br;
    e.mp   = m_mp;

    @(negedge clk);
    ex_valid = 1'b1; ex_instr = enc(k, imm); ex_pc = pc;
    rs1_data = r1; rs2_data = r2; ex_pred_taken = pt; ex_pred_pc = ppc;
    #1;
    check({tag, ":ready_in"}, {31'b0, ex_ready}, 32'd1);
    check({tag, ":link"}, link_data, pc + 32'd4);
    sb.push_back(e);

    @(negedge clk);
    ex_valid = 1'b0;
    e = sb.pop_front();
    check({tag, ":br_cnt"}, {30'b0, br_cnt}, e.br);
    check({tag, ":misp_cnt"}, {30'b0, misp_cnt}, e.mp);
    check({tag, ":redir_valid"}, {31'b0, redir_valid}, {31'b0, e.misp});
    check({tag, ":flush"}, {31'b0, flush}, {31'b0, e.misp});
    check({tag, ":ready_out"}, {31'b0, ex_ready}, {31'b0, !e.misp});
    if (!e.misp) return;
    check({tag, ":redir_pc"}, redir_pc, e.pc);

    if (w < 0) begin
      // Reset lands while a handshake is also offered; reset must win.
      redir_ready = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      redir_ready = 1'b0;
      m_br = 0;
      m_mp = 0;
      sb.delete();
      check({tag, ":rst_redir_valid"}, {31'b0, redir_valid}, 32'd0);
      check({tag, ":rst_flush"}, {31'b0, flush}, 32'd0);
      check({tag, ":rst_redir_pc"}, redir_pc, 32'd0);
      check({tag, ":rst_br"}, {30'b0, br_cnt}, 32'd0);
      check({tag, ":rst_misp"}, {30'b0, misp_cnt}, 32'd0);
      check({tag, ":rst_ready"}, {31'b0, ex_ready}, 32'd1);
      return;
    end

    fl = 1;
    for (int i = 0; i < w; i++) begin
      // Offer a would-be mispredict that must be ignored while stalled.
      ex_valid = 1'b1; ex_instr = enc(K_BEQ, 32'd8); ex_pc = 32'h7000;
      rs1_data = 32'd1; rs2_data = 32'd2; ex_pred_taken = 1'b1; ex_pred_pc = 32'h0;
      @(negedge clk);
      check({tag, ":hold_valid"}, {31'b0, redir_valid}, 32'd1);
      check({tag, ":hold_pc"}, redir_pc, e.pc);
      check({tag, ":hold_ready"}, {31'b0, ex_ready}, 32'd0);
      fl += int'(flush);
    end
    ex_valid = 1'b0;
    redir_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      redir_ready = 1'b0;
      if (!flush) break;
      fl++;
    end
    check({tag, ":flush_len"}, fl, 1 + w + FC);
    check({tag, ":post_valid"}, {31'b0, redir_valid}, 32'd0);
    check({tag, ":post_ready"}, {31'b0, ex_ready}, 32'd1);
    check({tag, ":post_br"}, {30'b0, br_cnt}, e.br);
    check({tag, ":post_misp"}, {30'b0, misp_cnt}, e.mp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; ex_instr = '0; ex_pc = '0;
    ex_pred_taken = 1'b0; ex_pred_pc = '0; rs1_data = '0; rs2_data = '0;
    redir_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset:redir_valid", {31'b0, redir_valid}, 32'd0);
    check("reset:redir_pc", redir_pc, 32'd0);
    check("reset:flush", {31'b0, flush}, 32'd0);
    check("reset:br_cnt", {30'b0, br_cnt}, 32'd0);
    check("reset:misp_cnt", {30'b0, misp_cnt}, 32'd0);
    check("reset:ex_ready", {31'b0, ex_ready}, 32'd1);
    rst_n = 1'b1;

    issue("beq_hit",   K_BEQ,  32'h100, 32'd16, 32'd5, 32'd5, 1'b1, 32'h110, 0);
    issue("bne_misp",  K_BNE,  32'h200, 32'd8,  32'd7, 32'd7, 1'b1, 32'h208, 0);
    issue("jalr_misp", K_JALR, 32'h300, 32'd2,  32'h1001, 32'd0, 1'b1, 32'h1000, 0);
    issue("beq_stall", K_BEQ,  32'h400, 32'h10, 32'd1, 32'd2, 1'b1, 32'h410, 5);
    issue("addi",      K_ADDI, 32'h500, 32'd4,  32'd1, 32'd2, 1'b1, 32'h0, 0);
    issue("blt",       K_BLT,  32'h504, 32'd8,  32'd1, 32'd2, 1'b1, 32'h50C, 0);
    issue("rst_redir", K_JAL,  32'h600, 32'h40, 32'd0, 32'd0, 1'b0, 32'h0, -1);

    issue("jal_wrap",  K_JAL,  32'hFFFF_FFF0, 32'h20, 32'd0, 32'd0, 1'b0, 32'h0, 0);
    issue("jal_hit",   K_JAL,  32'hFFFF_FFF0, 32'h20, 32'd0, 32'd0, 1'b1, 32'h10, 0);
    issue("bne_neg",   K_BNE,  32'h1000, 32'hFFFF_FFF0, 32'd3, 32'd4, 1'b1, 32'h0FF4, 0);
    issue("beq_nt",    K_BEQ,  32'h2000, 32'd8, 32'd1, 32'd2, 1'b0, 32'h0, 0);
    issue("jalr_lsb",  K_JALR, 32'h3000, 32'hFFFF_FFFF, 32'h2001, 32'd0, 1'b0, 32'h0, 0);
    issue("sat_misp",  K_BEQ,  32'h4000, 32'd8, 32'd5, 32'd5, 1'b0, 32'h0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
